// File: rtl/priority_pkg.sv
// priority_pkg
//   Shared widths and defaults for the priority-code FIFO.
//   CODE_W    : one-hot priority code width (six sources plus "none")
//   IDX_W     : width of a decoded bit position (0..6)
//   DEPTH_DEF : default FIFO depth
//   DROP_W    : width of the saturating drop counter
package priority_pkg;

  localparam int CODE_W    = 7;
  localparam int IDX_W     = 3;
  localparam int DEPTH_DEF = 4;
  localparam int DROP_W    = 8;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [DROP_W-1:0] drop_t;

endpackage

// File: rtl/onehot_to_idx.sv
// onehot_to_idx
//   Combinational decode of a priority code into the position of its set bit.
//   Ports:
//     code      in  CODE_W  priority code
//     idx       out IDX_W   position of the (highest) set bit
//     is_onehot out 1       exactly one bit of code is set
module onehot_to_idx #(
  parameter int CODE_W = priority_pkg::CODE_W
) (
  input  logic [CODE_W-1:0]             code,
  output logic [priority_pkg::IDX_W-1:0] idx,
  output logic                          is_onehot
);
  import priority_pkg::*;

  localparam int OW = $clog2(CODE_W + 1);

  logic [OW-1:0] ones;

  always_comb begin
    idx  = '0;
    ones = '0;
    for (int i = 0; i < CODE_W; i++) begin
      if (code[i]) begin
        idx  = IDX_W'(i);
        ones = ones + OW'(1);
      end
    end
  end

  assign is_onehot = (ones == OW'(1));

endmodule

// File: rtl/priority_fifo.sv
// priority_fifo
//   Queues decoded one-hot priority codes. Illegal codes are rejected and
//   latch a sticky error; legal codes that arrive while full are counted.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     code, in_valid      input priority code and its qualifier
//     in_ready            FIFO not full
//     out_idx, out_valid  head entry and its qualifier
//     out_ready           consumer takes the head this cycle
//     count               current occupancy
//     err                 sticky: a non-one-hot code was offered
//     drop_cnt            legal codes lost to a full FIFO, saturating
module priority_fifo #(
  parameter int DEPTH  = priority_pkg::DEPTH_DEF,
  parameter int CODE_W = priority_pkg::CODE_W
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CODE_W-1:0]               code,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [priority_pkg::IDX_W-1:0]  out_idx,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            err,
  output logic [priority_pkg::DROP_W-1:0] drop_cnt
);
  import priority_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  idx_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  drop_t            drop_q, drop_d;

  idx_t code_idx;
  logic code_onehot;
  logic full, push, pop, drop, bad;

  onehot_to_idx #(.CODE_W(CODE_W)) u_dec (
    .code      (code),
    .idx       (code_idx),
    .is_onehot (code_onehot)
  );

  assign full = (count_q == CNT_W'(DEPTH));
  assign push = in_valid && !full && code_onehot;
  assign pop  = (count_q != '0) && out_ready;
  // A full FIFO refuses legal codes even when the head is popped in the
  // same cycle, so in_ready never depends on out_ready.
  assign drop = in_valid && code_onehot && full;
  assign bad  = in_valid && !code_onehot;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    err_d  = err_q | bad;
    drop_d = (drop && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      drop_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
      drop_q   <= drop_d;
      if (push) mem_q[wr_ptr_q] <= code_idx;
    end
  end

  assign in_ready  = !full;
  assign out_valid = (count_q != '0);
  assign out_idx   = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign err       = err_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_priority_fifo.sv
module tb_priority_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] code = '0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic [2:0] out_idx;
  logic       out_valid;
  logic [2:0] count;
  logic       err;
  logic [7:0] drop_cnt;

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int exp_q[$];

  priority_fifo #(.DEPTH(4), .CODE_W(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .code      (code),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .err       (err),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pop presented by the DUT is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      pops++;
      if (exp_q.size() == 0) chk("unexpected_pop", 32'd1, 32'd0);
      else chk("out_idx", {29'd0, out_idx}, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [6:0] c, input int idx, input bit accepted);
    code     = c;
    in_valid = 1'b1;
    if (accepted) exp_q.push_back(idx);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) tick();
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_err", err, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;

    // First push on the first edge, visible one cycle later
    push(7'h40, 6, 1);
    chk("first_push_count", count, 1);
    chk("first_push_valid", out_valid, 1);
    chk("first_push_idx", out_idx, 6);
    push(7'h08, 3, 1);
    push(7'h01, 0, 1);
    chk("three_count", count, 3);
    drain(3);
    chk("three_drained_valid", out_valid, 0);
    chk("three_pops", pops, 3);

    // Overfill by one
    push(7'h02, 1, 1);
    push(7'h04, 2, 1);
    push(7'h10, 4, 1);
    push(7'h20, 5, 1);
    push(7'h01, 0, 0);
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    chk("full_drop", drop_cnt, 1);
    chk("full_err", err, 0);

    // Full with simultaneous pop: push still refused
    code = 7'h02; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("fullpop_count", count, 3);
    chk("fullpop_drop", drop_cnt, 2);
    drain(3);
    chk("fullpop_drained", count, 0);

    // Streaming at occupancy 2 across pointer wrap
    push(7'h40, 6, 1);
    push(7'h08, 3, 1);
    chk("stream_pre_count", count, 2);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [6:0] one;
      one  = 7'h01;
      code = one << (i % 7);
      exp_q.push_back(i % 7);
      tick();
      chk("stream_count", count, 2);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    out_ready = 1'b0;
    chk("stream_drained", count, 0);
    chk("stream_pops", pops, 19);

    // Illegal codes
    push(7'h00, 0, 0);
    chk("zero_code_count", count, 0);
    chk("zero_code_err", err, 1);
    push(7'h41, 0, 0);
    chk("multi_code_count", count, 0);
    chk("multi_code_drop", drop_cnt, 2);
    repeat (3) tick();
    chk("err_sticky", err, 1);

    // Asynchronous reset mid-cycle with entries stored
    push(7'h02, 1, 1);
    push(7'h04, 2, 1);
    push(7'h08, 3, 1);
    chk("pre_reset_count", count, 3);
    code = 7'h10; in_valid = 1'b1;
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_count", count, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_idx", out_idx, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_err", err, 0);
    chk("arst_drop", drop_cnt, 0);
    tick();
    chk("held_reset_count", count, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // Drop counter saturation
    push(7'h01, 0, 1);
    push(7'h02, 1, 1);
    push(7'h04, 2, 1);
    push(7'h08, 3, 1);
    code = 7'h20; in_valid = 1'b1;
    repeat (254) tick();
    chk("drop_254", drop_cnt, 254);
    repeat (46) tick();
    in_valid = 1'b0;
    chk("drop_sat", drop_cnt, 255);
    chk("drop_sat_count", count, 4);
    chk("drop_sat_err", err, 0);
    drain(4);
    chk("final_count", count, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_fifo.md
PRIORITY_FIFO -- requirements
Module: priority_fifo

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of FIFO entries (power of two, 2..16).
REQ-002 Parameter CODE_W, default 7, SHALL set the one-hot code width (6-bit priority result plus the "none" bit).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 code  input  CODE_W  SHALL carry the one-hot priority code (bit 6 = SW[5] highest ... bit 0 = no input set).
REQ-006 in_valid  input  1  SHALL qualify code.
REQ-007 in_ready  output  1  SHALL indicate a push is accepted this cycle.
REQ-008 out_idx  output  3  SHALL carry the head entry's index (0..6).
REQ-009 out_valid  output  1  SHALL indicate out_idx is valid.
REQ-010 out_ready  input  1  SHALL indicate the consumer takes the head this cycle.
REQ-011 count  output  $clog2(DEPTH)+1  SHALL give the current occupancy.
REQ-012 err  output  1  SHALL be a sticky flag for a rejected non-one-hot code.
REQ-013 drop_cnt  output  8  SHALL count valid codes lost to a full FIFO, saturating at 255.

Function
REQ-014 A push SHALL occur when in_valid && in_ready && code is exactly one-hot.
REQ-015 The pushed value SHALL be the bit position of the set bit (code 7'b1000000 -> 6, 7'b0000001 -> 0).
REQ-016 A code with zero bits or more than one bit set, offered with in_valid, SHALL NOT be pushed, SHALL set err, and SHALL NOT increment drop_cnt.
REQ-017 in_ready SHALL equal !full (count == DEPTH), with no combinational path from out_ready.
REQ-018 A pop SHALL occur when out_valid && out_ready.
REQ-019 out_valid SHALL equal (count != 0).
REQ-020 out_idx SHALL be driven from the head register; a push into an empty FIFO SHALL appear on out_idx/out_valid one cycle later (latency 1).
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-022 At full, a valid one-hot code SHALL be refused, and drop_cnt SHALL increment by 1, even if a pop occurs in the same cycle.
REQ-023 At empty, out_ready SHALL have no effect.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 err SHALL remain set until reset.
REQ-026 drop_cnt SHALL hold at 255 once reached.

Reset
REQ-027 rst_n low SHALL immediately clear the pointers, count=0, out_valid=0, out_idx=0, err=0 and drop_cnt=0, and SHALL set in_ready=1.
REQ-028 Reset asserted mid-stream SHALL discard all stored entries; no pop or push SHALL be reported in the reset cycle.
REQ-029 After rst_n deasserts, the first push SHALL be accepted on the first rising edge.

Structure
REQ-030 Package priority_pkg SHALL hold CODE_W=7, IDX_W=3, DEPTH default and the drop counter width (8).
REQ-031 Sub-module onehot_to_idx SHALL be purely combinational: code in, idx and is_onehot out.
REQ-032 FIFO storage SHALL be a register array of DEPTH x IDX_W, with no RAM inference required.

Verification
REQ-033 Reset, then push codes 0x40, 0x08, 0x01 with out_ready=0 -> count=3; then out_ready=1 -> out_idx sequence 6, 3, 0; then out_valid=0.
REQ-034 Push 5 valid codes with DEPTH=4 and out_ready=0 -> count=4, in_ready=0, drop_cnt=1, err=0.
REQ-035 Push code 0x00, then 0x41 -> nothing pushed, count=0, err=1 and remains 1.
REQ-036 FIFO full, in_valid with code 0x02 and out_ready=1 simultaneously -> pop occurs, push refused, count=3, drop_cnt+1.
REQ-037 Continuous push and pop with count=2 for 10 cycles -> count stays 2, output order matches input, pointers wrap.
REQ-038 Assert rst_n low asynchronously, mid-cycle, with count=3 -> outputs clear before the next edge; 300 drops -> drop_cnt=255.
